// File: rtl/dual_stream_aligner.sv
// dual_stream_aligner
//   Buffers a master and a slave pixel stream in two independent FIFOs and
//   emits them as aligned pairs: the n-th master pixel of a frame is always
//   output together with the n-th slave pixel of that frame.
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_h_aync_m/i_v_aync_m   master line-valid / frame-valid
//   i_data_m                master pixel
//   i_h_aync_s/i_v_aync_s   slave line-valid / frame-valid
//   i_data_s                slave pixel
//   o_h_aync                aligned pair valid
//   o_v_aync                aligned frame valid (high in RUN and DRAIN)
//   o_data_m/o_data_s       aligned pair, zero when o_h_aync is low
//   o_err                   sticky: [0] FIFO overflow, [1] frame length mismatch
//   o_fill_m/o_fill_s       FIFO occupancy, only with FILL_LEVEL_EN defined
//
// Optional feature macro: FILL_LEVEL_EN
module dual_stream_aligner #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_FIFO_DEPTH = 16,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_h_aync_m,
  input  logic                    i_v_aync_m,
  input  logic [P_DATA_WIDTH-1:0] i_data_m,
  input  logic                    i_h_aync_s,
  input  logic                    i_v_aync_s,
  input  logic [P_DATA_WIDTH-1:0] i_data_s,
  output logic                    o_h_aync,
  output logic                    o_v_aync,
  output logic [P_DATA_WIDTH-1:0] o_data_m,
  output logic [P_DATA_WIDTH-1:0] o_data_s,
  output logic [1:0]              o_err
`ifdef FILL_LEVEL_EN
  ,
  output logic [P_ADDR_WIDTH:0]   o_fill_m,
  output logic [P_ADDR_WIDTH:0]   o_fill_s
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  localparam logic [P_ADDR_WIDTH:0] PTR_ONE = {{P_ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                    state_q, state_d;
  logic [P_DATA_WIDTH-1:0]   mem_m_q [P_FIFO_DEPTH];
  logic [P_DATA_WIDTH-1:0]   mem_s_q [P_FIFO_DEPTH];
  // Pointers carry one extra MSB so full and empty can be told apart.
  logic [P_ADDR_WIDTH:0]     wr_m_q, wr_m_d, rd_m_q, rd_m_d;
  logic [P_ADDR_WIDTH:0]     wr_s_q, wr_s_d, rd_s_q, rd_s_d;
  // Write pointers captured on DRAIN entry: entries below the mark belong to
  // the frame being drained, entries above it to the next frame.
  logic [P_ADDR_WIDTH:0]     mark_m_q, mark_m_d, mark_s_q, mark_s_d;
  logic                      h_q;
  logic [P_DATA_WIDTH-1:0]   data_m_q, data_s_q;
  logic [1:0]                err_q, err_d;

  logic empty_m, empty_s, full_m, full_s;
  logic old_m, old_s, avail_m, avail_s, pop;
  logic req_m, req_s, wr_m, wr_s, ovf;
  logic flush_m, flush_s;

  always_comb begin
    empty_m = (wr_m_q == rd_m_q);
    empty_s = (wr_s_q == rd_s_q);
    full_m  = (wr_m_q[P_ADDR_WIDTH] != rd_m_q[P_ADDR_WIDTH]) &&
              (wr_m_q[P_ADDR_WIDTH-1:0] == rd_m_q[P_ADDR_WIDTH-1:0]);
    full_s  = (wr_s_q[P_ADDR_WIDTH] != rd_s_q[P_ADDR_WIDTH]) &&
              (wr_s_q[P_ADDR_WIDTH-1:0] == rd_s_q[P_ADDR_WIDTH-1:0]);
    old_m   = (rd_m_q != mark_m_q);
    old_s   = (rd_s_q != mark_s_q);
    // While draining only the old frame may pair, so new-frame pixels that
    // arrive early never get matched with the old frame's leftovers.
    avail_m = (state_q == ST_DRAIN) ? old_m : !empty_m;
    avail_s = (state_q == ST_DRAIN) ? old_s : !empty_s;
    pop     = avail_m && avail_s;
    req_m   = i_h_aync_m && i_v_aync_m;
    req_s   = i_h_aync_s && i_v_aync_s;
    // A full FIFO still takes a pixel if a slot frees up on the same edge.
    wr_m    = req_m && (!full_m || pop);
    wr_s    = req_s && (!full_s || pop);
    ovf     = (req_m && !wr_m) || (req_s && !wr_s);
  end

  always_comb begin
    state_d  = state_q;
    mark_m_d = mark_m_q;
    mark_s_d = mark_s_q;
    flush_m  = 1'b0;
    flush_s  = 1'b0;
    case (state_q)
      ST_IDLE: if (pop) state_d = ST_RUN;
      ST_RUN: begin
        if (!i_v_aync_m && !i_v_aync_s) begin
          state_d  = ST_DRAIN;
          mark_m_d = wr_m_d;
          mark_s_d = wr_s_d;
        end
      end
      ST_DRAIN: begin
        // One side ran out of old entries: drop the other side's surplus.
        if (!old_m || !old_s) begin
          state_d = ST_IDLE;
          flush_m = old_m;
          flush_s = old_s;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_m_d = wr_m ? wr_m_q + PTR_ONE : wr_m_q;
    wr_s_d = wr_s ? wr_s_q + PTR_ONE : wr_s_q;
    rd_m_d = flush_m ? mark_m_q : (pop ? rd_m_q + PTR_ONE : rd_m_q);
    rd_s_d = flush_s ? mark_s_q : (pop ? rd_s_q + PTR_ONE : rd_s_q);
    err_d  = err_q | {flush_m || flush_s, ovf};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      wr_m_q   <= '0;
      rd_m_q   <= '0;
      wr_s_q   <= '0;
      rd_s_q   <= '0;
      mark_m_q <= '0;
      mark_s_q <= '0;
      h_q      <= 1'b0;
      data_m_q <= '0;
      data_s_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_m_q   <= wr_m_d;
      rd_m_q   <= rd_m_d;
      wr_s_q   <= wr_s_d;
      rd_s_q   <= rd_s_d;
      mark_m_q <= mark_m_d;
      mark_s_q <= mark_s_d;
      h_q      <= pop;
      data_m_q <= pop ? mem_m_q[rd_m_q[P_ADDR_WIDTH-1:0]] : '0;
      data_s_q <= pop ? mem_s_q[rd_s_q[P_ADDR_WIDTH-1:0]] : '0;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_m) mem_m_q[wr_m_q[P_ADDR_WIDTH-1:0]] <= i_data_m;
    if (wr_s) mem_s_q[wr_s_q[P_ADDR_WIDTH-1:0]] <= i_data_s;
  end

  assign o_h_aync = h_q;
  assign o_v_aync = (state_q != ST_IDLE);
  assign o_data_m = data_m_q;
  assign o_data_s = data_s_q;
  assign o_err    = err_q;

`ifdef FILL_LEVEL_EN
  logic [P_ADDR_WIDTH:0] fill_m_q, fill_s_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fill_m_q <= '0;
      fill_s_q <= '0;
    end else begin
      fill_m_q <= wr_m_d - rd_m_d;
      fill_s_q <= wr_s_d - rd_s_d;
    end
  end

  assign o_fill_m = fill_m_q;
  assign o_fill_s = fill_s_q;
`endif

endmodule

// File: doc/dual_stream_aligner.md
DUAL_STREAM_ALIGNER -- requirements
Module: dual_stream_aligner

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 8, pixel width of both streams.
REQ-002 SHALL have parameter P_FIFO_DEPTH, default 16, entries per stream buffer (power of two, >=4).
REQ-003 SHALL have parameter P_ADDR_WIDTH, default 4, log2(P_FIFO_DEPTH).
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 i_h_aync_m / i_v_aync_m  in  1 each  master line-valid / frame-valid.
REQ-007 i_data_m  in  P_DATA_WIDTH  master pixel.
REQ-008 i_h_aync_s / i_v_aync_s  in  1 each  slave line-valid / frame-valid.
REQ-009 i_data_s  in  P_DATA_WIDTH  slave pixel.
REQ-010 o_h_aync  out  1  aligned pair valid.
REQ-011 o_v_aync  out  1  aligned frame-valid.
REQ-012 o_data_m / o_data_s  out  P_DATA_WIDTH each  aligned master/slave pixel pair.
REQ-013 o_err  out  2  sticky: bit0 overflow, bit1 frame mismatch.

Function
REQ-014 SHALL buffer each stream in its own FIFO; write on cycle with h_aync && v_aync of that stream.
REQ-015 SHALL pop both FIFOs in the same cycle only when both non-empty; popped pair registered to o_data_m/o_data_s with o_h_aync=1 after next edge.
REQ-016 Latency: pixel written at edge k whose partner is already queued SHALL appear on outputs after edge k+1; simultaneous m/s writes into empty FIFOs likewise after edge k+1.
REQ-017 When o_h_aync=0, o_data_m and o_data_s SHALL be 0.
REQ-018 Pair order SHALL be preserved: n-th master pixel of a frame always paired with n-th slave pixel.
REQ-019 Write to full FIFO SHALL be accepted only if a pop occurs same cycle; otherwise pixel dropped and o_err[0] set.
REQ-020 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-021 IDLE -> RUN when first pair is popped; o_v_aync goes 1 with that first pair.
REQ-022 RUN -> DRAIN when both i_v_aync_m and i_v_aync_s are 0 (sampled same cycle).
REQ-023 DRAIN: continue pairing; -> IDLE when either FIFO empty; any remaining entries in other FIFO SHALL be flushed in the transition cycle and o_err[1] set if count was nonzero.
REQ-024 o_v_aync SHALL be 1 in RUN and DRAIN, 0 in IDLE; it falls on the cycle after last pair output.
REQ-025 New-frame writes arriving during DRAIN SHALL be held in FIFO and not flushed unless belonging to the drained stream's surplus (flush only entries written before DRAIN entry).
REQ-026 Pointers SHALL wrap modulo P_FIFO_DEPTH; full/empty via extra pointer MSB.
REQ-027 o_err bits SHALL remain set until reset.

Reset
REQ-028 i_rst=1 SHALL immediately force: FSM IDLE, both FIFOs empty, o_h_aync=0, o_v_aync=0, o_data_m=0, o_data_s=0, o_err=0.
REQ-029 Reset mid-frame SHALL discard all buffered pixels; first post-reset pair pairs first post-reset writes.

Configuration
REQ-030 Macro FILL_LEVEL_EN defined: SHALL add outputs o_fill_m and o_fill_s (P_ADDR_WIDTH+1 bits each, registered FIFO occupancy, reset 0).
REQ-031 Macro FILL_LEVEL_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 Master 4 px starting cycle 10, slave same 4 px starting cycle 13, both v high -> 4 pairs, first after edge 14, o_v_aync rises with it, pairs (m0,s0)..(m3,s3).
REQ-033 Simultaneous m/s 8-px line, data m=i, s=2i -> o_h_aync high 8 consecutive cycles, latency 1 edge, values exact.
REQ-034 Slave stalled, master writes 17 px into depth 16 -> 17th dropped, o_err=2'b01, remains after slave resumes; 16 pairs out.
REQ-035 Frame end with master 5 px, slave 3 px -> 3 pairs, DRAIN->IDLE, 2 entries flushed, o_err[1]=1, o_v_aync=0.
REQ-036 Assert i_rst for 1 cycle with 6 entries buffered -> outputs 0 same cycle, FIFOs empty; next frame pairs from first new pixel.
REQ-037 With FILL_LEVEL_EN: master leads slave by 3 px -> o_fill_m peaks at 3, returns to 0 after last pair.
